// File: rtl/fifo_uart_drain.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fifo_uart_drain
//
// Read-side consumer of the tt_um_fifo storage. Whenever the FIFO holds data
// and i/o enable permits, one byte is popped and serialised as an asynchronous
// UART frame (start, DATA_W data bits LSB first, optional parity, stop) on a
// single line, so FIFO contents can be watched on one output pin.
//
// Configuration macro:
//   FIFO_DRAIN_PARITY_EN  defined   -> even-parity bit between DATA and STOP
//                         undefined -> no parity state, no parity register
//
// Ports:
//   clk           in   1        system clock, rising edge
//   rst           in   1        synchronous active-high reset
//   tx_enable     in   1        permits new pops (looked at only in IDLE)
//   fifo_empty    in   1        FIFO empty flag
//   fifo_rd_data  in   DATA_W   FIFO read data, valid the cycle after the pop
//   fifo_rd_en    out  1        one-cycle pop strobe
//   tx            out  1        UART line, idles high
//   busy          out  1        high from pop strobe to end of stop bit
//   frame_done    out  1        pulse on the last cycle of the stop bit
//   byte_count    out  8        frames completed since reset, wraps
//   state_dbg     out  3        current FSM state encoding (observation only)
//
// Handshake: fifo_rd_en is a single-cycle strobe, raised only from IDLE when
// fifo_empty is low; the FIFO answers with fifo_rd_data one cycle after the
// strobe and no other acknowledgement is expected.
// ----------------------------------------------------------------------------
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        byte_count,
    output logic [2:0]        state_dbg
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef FIFO_DRAIN_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [BIT_W-1:0]    r_bit;
    logic [DATA_W-1:0]   r_shift;
    logic                r_tx;
    logic                r_rd_en;
    logic                r_busy;
    logic                r_frame_done;
    logic [7:0]          r_byte_count;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                w_baud_last;
    logic                w_tx_nxt;
    logic                w_rd_en_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

`ifdef FIFO_DRAIN_PARITY_EN
    logic                r_parity;
    logic                w_parity_nxt;
`endif

    // Next-state and next-output logic. Every output is registered, so the
    // output values are derived from the state being entered, not the current.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_baud_last = (r_baud == BAUD_LAST);
`ifdef FIFO_DRAIN_PARITY_EN
        w_parity_nxt = r_parity;
`endif

        case (r_state)
            S_IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // The pop strobe is visible during this cycle; the FIFO data
                // follows one cycle later, in the first START cycle.
                w_state_nxt = S_START;
                w_baud_nxt  = '0;
            end
            S_START: begin
                if (r_baud == '0) begin
                    w_shift_nxt = fifo_rd_data;
`ifdef FIFO_DRAIN_PARITY_EN
                    w_parity_nxt = ^fifo_rd_data;
`endif
                end
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt = '0;
`ifdef FIFO_DRAIN_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
`ifdef FIFO_DRAIN_PARITY_EN
            S_PARITY: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef FIFO_DRAIN_PARITY_EN
            S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase

        w_rd_en_nxt = (r_state == S_IDLE) && (w_state_nxt == S_FETCH);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        // Entering the last stop-bit cycle.
        w_done_nxt  = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_tx         <= 1'b1;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_byte_count <= 8'd0;
`ifdef FIFO_DRAIN_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_tx         <= w_tx_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_done_nxt;
            if (w_done_nxt) begin
                r_byte_count <= r_byte_count + 8'd1;
            end
`ifdef FIFO_DRAIN_PARITY_EN
            r_parity     <= w_parity_nxt;
`endif
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign byte_count = r_byte_count;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_fifo_uart_drain.sv
`timescale 1ns/1ps
module tb_fifo_uart_drain;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef FIFO_DRAIN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (DW + 2 + PAR) * CPB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          tx_enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          frame_done;
    logic [7:0]    byte_count;
    logic [2:0]    state_dbg;

    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_enable    (tx_enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done),
        .byte_count   (byte_count),
        .state_dbg    (state_dbg)
    );

    // ---------------- counters / scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [DW-1:0] mem [0:1023];
    int n_pushed = 0;
    int n_popped = 0;
    assign fifo_empty = (n_pushed == n_popped);

    initial begin
        fifo_rd_data = '0;
        forever begin
            @(posedge clk);
            if (fifo_rd_en && (n_popped != n_pushed)) begin
                fifo_rd_data <= mem[n_popped];
                n_popped     <= n_popped + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] b);
        mem[n_pushed] = b;
        n_pushed = n_pushed + 1;
        exp_q.push_back(b);
    endtask

    // ---------------- line monitor ----------------
    logic          mon_active = 1'b0;
    int            mon_cnt    = 0;
    logic [DW-1:0] mon_byte   = '0;
    int            idle_run   = 0;
    int            exp_gap    = -1;
    logic [7:0]    exp_frames = 8'd0;
    int            pops       = 0;
    logic          prev_rd_en = 1'b0;

    initial begin
        int b;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
                idle_run   = 0;
                exp_frames = 8'd0;
            end else begin
                if (!mon_active) begin
                    if (tx == 1'b0) begin
                        if (exp_gap >= 0) check("gap_idle_cycles", idle_run, exp_gap);
                        mon_active = 1'b1;
                        mon_cnt    = 0;
                        mon_byte   = '0;
                    end else begin
                        idle_run++;
                    end
                end else begin
                    mon_cnt++;
                end
                if (mon_active) begin
                    check("busy_in_frame", busy, 1);
                    check("frame_done_pos", frame_done, (mon_cnt == FRAME - 1));
                    if ((mon_cnt % CPB) == CPB / 2) begin
                        b = mon_cnt / CPB;
                        if (b == 0) check("start_bit", tx, 0);
                        else if (b <= DW) mon_byte[b-1] = tx;
                        else if (PAR == 1 && b == DW + 1) check("parity_bit", tx, ^mon_byte);
                        else check("stop_bit", tx, 1);
                    end
                    if (mon_cnt == FRAME - 1) begin
                        exp_frames = exp_frames + 8'd1;
                        check("byte_count", byte_count, exp_frames);
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                        check("rx_byte", mon_byte, e);
                        mon_active = 1'b0;
                        idle_run   = 0;
                    end
                end
                if (fifo_rd_en) begin
                    check("rd_en_while_empty", fifo_empty, 0);
                    check("rd_en_one_cycle", prev_rd_en, 0);
                    pops++;
                end
            end
            prev_rd_en = fifo_rd_en;
        end
    end

    task automatic wait_start(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (mon_active) break;
        end
        check("start_timeout", mon_active, 1);
    endtask

    task automatic wait_frame_end(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (!mon_active) break;
        end
        check("frame_end_timeout", mon_active, 0);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (exp_q.size() == 0 && !mon_active && n_popped == n_pushed) break;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int pops0;
        rst       = 1'b1;
        tx_enable = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_byte_count", byte_count, 0);

        // 1: single 0xA5 frame, pop-to-start latency
        step();
        pops0 = pops;
        push(8'hA5);
        tx_enable = 1'b1;
        @(negedge clk);
        check("t1_no_pop_yet", fifo_rd_en, 0);
        @(negedge clk);
        check("t1_rd_en", fifo_rd_en, 1);
        check("t1_fetch_tx", tx, 1);
        check("t1_fetch_busy", busy, 1);
        @(negedge clk);
        check("t1_start_tx", tx, 0);
        wait_drain(200);
        check("t1_pops", pops - pops0, 1);
        check("t1_count", byte_count, 1);

        // 2: three back-to-back frames with a two-cycle gap
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_start(20);
        exp_gap = 2;
        wait_drain(500);
        exp_gap = -1;
        check("t2_count", byte_count, 4);

        // 3: empty FIFO with enable high
        pops0 = pops;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t3_rd_en", fifo_rd_en, 0);
            check("t3_tx", tx, 1);
            check("t3_busy", busy, 0);
        end
        step();

        // 4: enable dropped during data bit 3
        push(8'h81);
        push(8'h42);
        wait_start(20);
        repeat (4 * CPB) step();
        tx_enable = 1'b0;
        pops0 = pops;
        wait_frame_end(200);
        repeat (40) step();
        check("t4_no_pop_disabled", pops, pops0);
        check("t4_entry_held", n_pushed - n_popped, 1);
        tx_enable = 1'b1;
        wait_drain(200);

        // 5: reset during data bit 5
        push(8'h5A);
        push(8'h66);
        wait_start(20);
        repeat (6 * CPB) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_tx", tx, 1);
        check("t5_busy", busy, 0);
        check("t5_count", byte_count, 0);
        check("t5_done", frame_done, 0);
        void'(exp_q.pop_front());  // aborted byte is lost, not re-sent
        wait_drain(200);
        check("t5_count_after", byte_count, 1);

        // 6: parity patterns (plain frames when parity is compiled out)
        push(8'h07);
        push(8'h03);
        wait_drain(300);

        // random burst, drives byte_count through its wrap
        for (int i = 0; i < 260; i++) begin
            push(8'($urandom_range(0, 255)));
        end
        wait_drain(20000);
        check("burst_count_wrap", byte_count, exp_frames);
        check("burst_count_value", byte_count, 8'(3 + 260));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
